// File: rtl/rv32i_mem_arbiter.sv
// Arbitrates one single-port memory between the fetch and data ports of rv32i_core.
// Data wins by default; a burst counter forces a fetch grant after MAX_D_BURST data grants.
module rv32i_mem_arbiter #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MAX_D_BURST = 4,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [2:0]        d_ctrl,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   output logic              bus_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [2:0]        mem_ctrl,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned BW = $clog2(MAX_D_BURST + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC);
   localparam logic [BW-1:0] BurstMax = BW'(MAX_D_BURST);
   localparam logic [TW-1:0] TmoLast  = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StDone} state_e;

   state_e        state;
   logic [BW-1:0] burst_cnt;
   logic [TW-1:0] tmo_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= StIdle;
         burst_cnt <= '0;
         tmo_cnt   <= '0;
         if_rdata  <= '0;
         if_valid  <= 1'b0;
         d_rdata   <= '0;
         d_valid   <= 1'b0;
         bus_err   <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_ctrl  <= '0;
      end else begin
         // Completion pulses live only for the single DONE cycle.
         if_valid <= 1'b0;
         d_valid  <= 1'b0;
         bus_err  <= 1'b0;
         unique case (state)
            StIdle: begin
               if (d_req && (!if_req || burst_cnt < BurstMax)) begin
                  state     <= StBusyD;
                  mem_req   <= 1'b1;
                  mem_we    <= d_we;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
                  mem_ctrl  <= d_ctrl;
                  if (!if_req) begin
                     burst_cnt <= '0;
                  end else if (burst_cnt != BurstMax) begin
                     burst_cnt <= burst_cnt + 1'b1;
                  end
               end else if (if_req) begin
                  state     <= StBusyI;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= if_addr;
                  mem_wdata <= '0;
                  mem_ctrl  <= 3'b010;
                  burst_cnt <= '0;
               end
            end
            StBusyI, StBusyD: begin
               if (mem_ack) begin
                  state   <= StDone;
                  mem_req <= 1'b0;
                  if (state == StBusyI) begin
                     if_rdata <= mem_rdata;
                     if_valid <= 1'b1;
                  end else begin
                     // Stores complete with zero read data.
                     d_rdata <= mem_we ? '0 : mem_rdata;
                     d_valid <= 1'b1;
                  end
               end else if (tmo_cnt == TmoLast) begin
                  state   <= StDone;
                  mem_req <= 1'b0;
                  bus_err <= 1'b1;
                  if (state == StBusyI) begin
                     if_rdata <= '0;
                     if_valid <= 1'b1;
                  end else begin
                     d_rdata <= '0;
                     d_valid <= 1'b1;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            StDone: begin
               tmo_cnt <= '0;
               state   <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Bench for rv32i_mem_arbiter: table of single accesses plus arbitration, timeout and reset
// sequences, checked through grant and completion scoreboards.
module tb_rv32i_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [2:0]  d_ctrl;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic        if_valid, d_valid, bus_err, mem_req, mem_we;
   logic [2:0]  mem_ctrl;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   rv32i_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MAX_D_BURST(4), .TIMEOUT_CYC(64)
   ) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ctrl(d_ctrl),
      .d_rdata(d_rdata), .d_valid(d_valid), .bus_err(bus_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ctrl(mem_ctrl), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        is_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  ctrl;
   } grant_t;

   typedef struct {
      logic        is_d;
      logic [31:0] rdata;
      logic        err;
   } cpl_t;

   typedef struct {
      logic        is_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  ctrl;
      int          delay;
      logic [31:0] exp_rdata;
   } vec_t;

   grant_t gq[$];
   cpl_t   cq[$];
   int     checks = 0;
   int     errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rd_model(input logic [31:0] a);
      return (a == 32'h100) ? 32'h0050_0093 : (a ^ 32'hC0DE_0000);
   endfunction

   // Memory responder: acks after ack_delay extra BUSY cycles when enabled.
   logic ack_en    = 1'b1;
   int   ack_delay = 0;
   int   busy_n    = 0;
   int   busy_max  = 0;
   always @(negedge clk) begin
      if (mem_req) busy_n = busy_n + 1;
      else busy_n = 0;
      if (busy_n > busy_max) busy_max = busy_n;
      mem_ack   = mem_req && ack_en && (busy_n > ack_delay);
      mem_rdata = mem_ack ? rd_model(mem_addr) : 32'hBAD0_BAD0;
   end

   // Grant and completion monitor.
   logic        prev_req = 1'b0;
   logic        s_we;
   logic [31:0] s_addr, s_wdata;
   logic [2:0]  s_ctrl;
   always @(negedge clk) begin
      grant_t g;
      cpl_t   c;
      if (!reset) begin
         if (mem_req && !prev_req) begin
            s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata; s_ctrl = mem_ctrl;
            if (gq.size() == 0) begin
               checks++; errors++;
               $display("FAIL grant_unexpected: got grant addr 0x%08h, expected none", mem_addr);
            end else begin
               g = gq.pop_front();
               chk("grant_addr", mem_addr, g.addr);
               chk("grant_we", 32'(mem_we), 32'(g.we));
               chk("grant_ctrl", 32'(mem_ctrl), 32'(g.ctrl));
               if (g.we) chk("grant_wdata", mem_wdata, g.wdata);
            end
         end else if (mem_req && prev_req) begin
            chk("hold_addr", mem_addr, s_addr);
            chk("hold_we_ctrl", {28'd0, mem_we, mem_ctrl}, {28'd0, s_we, s_ctrl});
            chk("hold_wdata", mem_wdata, s_wdata);
         end
         if (if_valid && d_valid) begin
            checks++; errors++;
            $display("FAIL both_valid: got if_valid=1 d_valid=1, expected at most one");
         end
         if (if_valid || d_valid) begin
            if (cq.size() == 0) begin
               checks++; errors++;
               $display("FAIL cpl_unexpected: got valid pulse (d=%0d), expected none", d_valid);
            end else begin
               c = cq.pop_front();
               chk("cpl_kind", 32'(d_valid), 32'(c.is_d));
               chk("cpl_rdata", d_valid ? d_rdata : if_rdata, c.rdata);
               chk("cpl_err", 32'(bus_err), 32'(c.err));
            end
         end
      end
      prev_req = mem_req;
   end

   task automatic wait_cpl(input int budget, output int lat);
      bit done = 1'b0;
      lat = -1;
      for (int i = 1; i <= budget && !done; i++) begin
         @(negedge clk);
         if (if_valid || d_valid) begin
            done = 1'b1;
            lat  = i;
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL wait_cpl: got no completion in %0d cycles, expected one", budget);
      end
   endtask

   task automatic push(input logic is_d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] ctrl,
                       input logic [31:0] rdata, input logic err);
      gq.push_back('{is_d, we, addr, wdata, is_d ? ctrl : 3'b010});
      cq.push_back('{is_d, rdata, err});
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: got no end of test, expected $finish");
      $fatal(1);
   end

   vec_t vec[7];
   int   lat;

   initial begin
      vec[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 3'b010, 0, 32'h0050_0093};
      vec[1] = '{1'b1, 1'b0, 32'h0000_2004, 32'h0, 3'b100, 0, 32'hC0DE_2004};
      vec[2] = '{1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 3'b010, 2, 32'h0};
      vec[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0, 3'b010, 3, 32'hC0DE_0104};
      vec[4] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0, 3'b000, 1, 32'hC0DE_3000};
      vec[5] = '{1'b1, 1'b1, 32'h0000_2008, 32'h1234_5678, 3'b001, 0, 32'h0};
      vec[6] = '{1'b0, 1'b0, 32'h0000_0110, 32'h0, 3'b010, 5, 32'hC0DE_0110};

      reset = 1'b1;
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0; d_ctrl = '0;
      repeat (3) @(negedge clk);
      chk("reset_ctl", {26'd0, mem_req, mem_we, if_valid, d_valid, bus_err, 1'b0}, 32'd0);
      chk("reset_addr", mem_addr, 32'd0);
      chk("reset_rdata", if_rdata | d_rdata | mem_wdata, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      foreach (vec[i]) begin
         ack_delay = vec[i].delay;
         if (vec[i].is_d) begin
            d_req = 1'b1; d_we = vec[i].we; d_addr = vec[i].addr;
            d_wdata = vec[i].wdata; d_ctrl = vec[i].ctrl;
         end else begin
            if_req = 1'b1; if_addr = vec[i].addr;
         end
         push(vec[i].is_d, vec[i].we, vec[i].addr, vec[i].wdata, vec[i].ctrl,
              vec[i].exp_rdata, 1'b0);
         wait_cpl(100, lat);
         chk("vec_latency", 32'(lat), 32'(2 + vec[i].delay));
         d_req = 1'b0; if_req = 1'b0;
         @(negedge clk);
      end

      // Simultaneous requests with an empty burst count: data first, then fetch.
      ack_delay = 0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2040; d_ctrl = 3'b101;
      if_req = 1'b1; if_addr = 32'h10C;
      push(1'b1, 1'b0, 32'h2040, 32'h0, 3'b101, 32'hC0DE_2040, 1'b0);
      push(1'b0, 1'b0, 32'h10C, 32'h0, 3'b010, 32'hC0DE_010C, 1'b0);
      wait_cpl(20, lat);
      chk("both_first_lat", 32'(lat), 32'd2);
      d_req = 1'b0;
      wait_cpl(20, lat);
      chk("both_fetch_lat", 32'(lat), 32'd3);
      if_req = 1'b0;
      @(negedge clk);

      // Both held: burst limit forces D,D,D,D,I,D,D,D,D,I.
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2010; d_ctrl = 3'b010;
      if_req = 1'b1; if_addr = 32'h108;
      for (int k = 0; k < 10; k++) begin
         if (k == 4 || k == 9) push(1'b0, 1'b0, 32'h108, 32'h0, 3'b010, 32'hC0DE_0108, 1'b0);
         else push(1'b1, 1'b0, 32'h2010, 32'h0, 3'b010, 32'hC0DE_2010, 1'b0);
      end
      for (int k = 0; k < 10; k++) wait_cpl(20, lat);
      d_req = 1'b0; if_req = 1'b0;
      @(negedge clk);
      chk("burst_drained", 32'(gq.size() + cq.size()), 32'd0);

      // No ack: abort after 64 BUSY cycles with bus_err and zero data.
      ack_en = 1'b0; busy_max = 0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2020; d_ctrl = 3'b010;
      push(1'b1, 1'b0, 32'h2020, 32'h0, 3'b010, 32'h0, 1'b1);
      wait_cpl(100, lat);
      chk("tmo_latency", 32'(lat), 32'd65);
      chk("tmo_req_cycles", 32'(busy_max), 32'd64);
      chk("tmo_req_low", 32'(mem_req), 32'd0);
      d_req = 1'b0; ack_en = 1'b1;
      @(negedge clk);

      // Access after an abort completes without bus_err.
      d_req = 1'b1; d_addr = 32'h2024;
      push(1'b1, 1'b0, 32'h2024, 32'h0, 3'b010, 32'hC0DE_2024, 1'b0);
      wait_cpl(20, lat);
      chk("post_tmo_lat", 32'(lat), 32'd2);
      d_req = 1'b0;
      @(negedge clk);

      // Reset during BUSY_D: mem_req drops at once, no completion pulse.
      ack_en = 1'b0;
      d_req = 1'b1; d_addr = 32'h2030;
      gq.push_back('{1'b1, 1'b0, 32'h2030, 32'h0, 3'b010});
      repeat (3) @(negedge clk);
      chk("rst_busy_req", 32'(mem_req), 32'd1);
      #2 reset = 1'b1;
      #1 chk("rst_req_low", {30'd0, mem_req, d_valid}, 32'd0);
      d_req = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0; ack_en = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_no_pulse", 32'(cq.size() + gq.size()), 32'd0);

      if_req = 1'b1; if_addr = 32'h100; ack_delay = 0;
      push(1'b0, 1'b0, 32'h100, 32'h0, 3'b010, 32'h0050_0093, 1'b0);
      wait_cpl(20, lat);
      chk("rst_fetch_lat", 32'(lat), 32'd2);
      if_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("final_queues", 32'(cq.size() + gq.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
